dispatch_mc: RTL and testbench

//  Multi-unit successor to the single-unit dispatcher. Decodes CAEP instructions and serves the AEG

---
 rtl/dispatch_mc_pkg.sv | 34 +++
 rtl/dispatch_mc_if.sv | 32 +++
 rtl/dispatch_aeg_file.sv | 94 +++++++++
 rtl/dispatch_mc.sv | 163 ++++++++++++++++
 tb/tb_dispatch_mc.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_mc_pkg.sv
// Shared states, AEG map, exception bit positions and helpers for the
// multi-unit CAEP dispatcher.
package dispatch_mc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } state_e;

    localparam logic [17:0] AEG_QBASE = 18'd0;
    localparam logic [17:0] AEG_EXC   = 18'd1;
    localparam logic [17:0] AEG_PART  = 18'd2;
    localparam logic [17:0] AEG_CFG   = 18'd3;
    localparam logic [17:0] AEG_STAT  = 18'd4;
    localparam logic [17:0] AEG_MASK  = 18'd5;

    localparam int EXC_UNIMPL  = 0;
    localparam int EXC_BAD_IDX = 1;
    localparam int EXC_RO_WR   = 2;
    localparam int EXC_EMPTY   = 3;

    localparam logic [7:0] ABI = 8'h01;

    // Bits needed to hold values 0..n-1 (never less than one).
    function automatic int f_enc_bits(input int n);
        int bits;
        bits = 1;
        while ((1 << bits) < n) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/dispatch_mc_if.sv
// Host-side dispatch bus: CAEP instruction issue, AEG access and status back
// to the host. The host drives the master modport, the dispatcher the slave.
interface dispatch_mc_if;

    logic        disp_inst_vld;
    logic [4:0]  disp_inst;
    logic [17:0] disp_aeg_idx;
    logic        disp_aeg_rd;
    logic        disp_aeg_wr;
    logic [63:0] disp_aeg_wr_data;
    logic [17:0] disp_aeg_cnt;
    logic [15:0] disp_exception;
    logic [63:0] disp_rtn_data;
    logic        disp_rtn_data_vld;
    logic        disp_idle;
    logic        disp_stall;

    modport master (
        output disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr,
               disp_aeg_wr_data,
        input  disp_aeg_cnt, disp_exception, disp_rtn_data, disp_rtn_data_vld,
               disp_idle, disp_stall
    );

    modport slave (
        input  disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr,
               disp_aeg_wr_data,
        output disp_aeg_cnt, disp_exception, disp_rtn_data, disp_rtn_data_vld,
               disp_idle, disp_stall
    );

endinterface

// File: rtl/dispatch_aeg_file.sv
// AEG register file: NA 64-bit registers with read-only decode, a one-cycle
// read pipe, sticky exception accumulation and bad-index/RO-write flags.
module dispatch_aeg_file
    import dispatch_mc_pkg::*;
#(
    parameter int FREQ = 0,
    parameter int PART = 0,
    parameter int NA   = 8,
    parameter int NU   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [17:0]   aeg_idx,
    input  logic          aeg_rd,
    input  logic          aeg_wr,
    input  logic [63:0]   aeg_wr_data,
    input  logic [3:0]    num_ae,
    input  logic [NU-1:0] unit_busy,
    input  logic          st_idle,
    input  logic [15:0]   exc_in,
    output logic [63:0]   rtn_data,
    output logic          rtn_vld,
    output logic          bad_idx,
    output logic          ro_wr,
    output logic [NU-1:0] mask,
    output logic [47:0]   qbase
);

    localparam logic [63:0] MASK_ONES = {{(64 - NU){1'b0}}, {NU{1'b1}}};

    logic [63:0] regs_q [NA];
    logic [63:0] regs_d [NA];
    logic [63:0] rtn_data_q, rtn_data_d;
    logic        rtn_vld_q, rtn_vld_d;
    logic        bad_idx_q, bad_idx_d;
    logic        ro_wr_q, ro_wr_d;
    logic        in_range;
    logic        ro_hit;
    logic [63:0] rd_val;

    always_comb begin
        in_range = aeg_idx < 18'(NA);
        ro_hit   = (aeg_idx == AEG_PART) || (aeg_idx == AEG_CFG) || (aeg_idx == AEG_STAT);

        rd_val = 64'hdeadbeefdeadbeef;
        if (in_range) begin
            rd_val = '0;
            for (int i = 0; i < NA; i++)
                if (aeg_idx == 18'(i)) rd_val = regs_q[i];
            if (aeg_idx == AEG_PART) rd_val = 64'(PART);
            if (aeg_idx == AEG_CFG)  rd_val = {28'b0, num_ae, 16'(FREQ), ABI, 8'(NU)};
            if (aeg_idx == AEG_STAT) rd_val = {47'b0, 16'(unit_busy), st_idle};
        end

        // The sticky register ORs in the current exception pulses on top of any write.
        regs_d = regs_q;
        for (int i = 0; i < NA; i++) begin
            if (aeg_wr && !ro_hit && aeg_idx == 18'(i))
                regs_d[i] = (18'(i) == AEG_MASK) ? (aeg_wr_data & MASK_ONES) : aeg_wr_data;
            if (18'(i) == AEG_EXC)
                regs_d[i] = regs_d[i] | {48'b0, exc_in};
        end

        rtn_data_d = aeg_rd ? rd_val : '0;
        rtn_vld_d  = aeg_rd;
        bad_idx_d  = (aeg_rd || aeg_wr) && !in_range;
        ro_wr_d    = aeg_wr && ro_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NA; i++)
                regs_q[i] <= (18'(i) == AEG_MASK) ? MASK_ONES : '0;
            rtn_data_q <= '0;
            rtn_vld_q  <= 1'b0;
            bad_idx_q  <= 1'b0;
            ro_wr_q    <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rtn_data_q <= rtn_data_d;
            rtn_vld_q  <= rtn_vld_d;
            bad_idx_q  <= bad_idx_d;
            ro_wr_q    <= ro_wr_d;
        end
    end

    assign rtn_data = rtn_data_q;
    assign rtn_vld  = rtn_vld_q;
    assign bad_idx  = bad_idx_q;
    assign ro_wr    = ro_wr_q;
    assign mask     = regs_q[int'(AEG_MASK)][NU-1:0];
    assign qbase    = regs_q[int'(AEG_QBASE)][47:0];

endmodule

// File: rtl/dispatch_mc.sv
// Multi-unit CAEP dispatcher: decodes caep0/caep1, serves the AEG file and
// launches the enabled personality units as a group through RESET/START/BUSY.
module dispatch_mc
    import dispatch_mc_pkg::*;
#(
    parameter int FREQ    = 0,
    parameter int PART    = 0,
    parameter int NA      = 8,
    parameter int NU      = 4,
    parameter int RST_CYC = 3,
    parameter int IDL_CYC = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    dispatch_mc_if.slave  disp,
    input  logic [3:0]    num_ae,
    output logic [47:0]   ctlQueBase,
    output logic [NU-1:0] unit_start,
    output logic [NU-1:0] unit_reset,
    input  logic [NU-1:0] unit_busy
);

    localparam int MAX_CYC = (RST_CYC > IDL_CYC) ? RST_CYC : IDL_CYC;
    localparam int CW      = f_enc_bits(MAX_CYC + 1);
    localparam logic [CW-1:0] RST_LD = CW'(RST_CYC);
    localparam logic [CW-1:0] IDL_LD = CW'(IDL_CYC);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NU-1:0] lmask_q, lmask_d;
    logic          caep1_q, caep1_d;
    logic [NU-1:0] start_q, start_d;
    logic [NU-1:0] ureset_q, ureset_d;
    logic          idle_q, idle_d;
    logic          unimpl_q, unimpl_d;
    logic          empty_q, empty_d;

    logic [63:0]   rtn_data;
    logic          rtn_vld;
    logic          bad_idx;
    logic          ro_wr;
    logic [NU-1:0] aeg_mask;
    logic [15:0]   exc;
    logic          caep_op;
    logic          kick;

    dispatch_aeg_file #(
        .FREQ (FREQ),
        .PART (PART),
        .NA   (NA),
        .NU   (NU)
    ) u_aeg (
        .clk         (clk),
        .reset_n     (reset_n),
        .aeg_idx     (disp.disp_aeg_idx),
        .aeg_rd      (disp.disp_aeg_rd),
        .aeg_wr      (disp.disp_aeg_wr),
        .aeg_wr_data (disp.disp_aeg_wr_data),
        .num_ae      (num_ae),
        .unit_busy   (unit_busy),
        .st_idle     (state_q == IDLE),
        .exc_in      (exc),
        .rtn_data    (rtn_data),
        .rtn_vld     (rtn_vld),
        .bad_idx     (bad_idx),
        .ro_wr       (ro_wr),
        .mask        (aeg_mask),
        .qbase       (ctlQueBase)
    );

    always_comb begin
        exc              = '0;
        exc[EXC_UNIMPL]  = unimpl_q;
        exc[EXC_BAD_IDX] = bad_idx;
        exc[EXC_RO_WR]   = ro_wr;
        exc[EXC_EMPTY]   = empty_q;

        caep_op = disp.disp_inst_vld && (disp.disp_inst <= 5'd1);
        kick    = caep_op && (|aeg_mask);

        state_d = state_q;
        cnt_d   = cnt_q;
        lmask_d = lmask_q;
        caep1_d = caep1_q;
        start_d = '0;

        // Counters load N and leave the state after exactly N cycles in it.
        case (state_q)
            IDLE: begin
                if (kick) begin
                    state_d = RESET;
                    cnt_d   = RST_LD;
                    lmask_d = aeg_mask;
                    caep1_d = disp.disp_inst[0];
                end
            end
            RESET: begin
                if (cnt_q == ONE) begin
                    state_d = START;
                    cnt_d   = RST_LD;
                    start_d = lmask_q;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            START: begin
                if (cnt_q == ONE) begin
                    state_d = BUSY;
                    cnt_d   = IDL_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            BUSY: begin
                if (|(unit_busy & lmask_q)) cnt_d = IDL_LD;
                else if (cnt_q == ONE)      state_d = IDLE;
                else                        cnt_d = cnt_q - ONE;
            end
            default: state_d = IDLE;
        endcase

        idle_d   = (state_d == IDLE);
        ureset_d = (state_d == IDLE || state_d == RESET) ? '1 : ~lmask_d;
        unimpl_d = disp.disp_inst_vld && (disp.disp_inst > 5'd1);
        empty_d  = caep_op && !(|aeg_mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lmask_q  <= '0;
            caep1_q  <= 1'b0;
            start_q  <= '0;
            ureset_q <= '1;
            idle_q   <= 1'b1;
            unimpl_q <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lmask_q  <= lmask_d;
            caep1_q  <= caep1_d;
            start_q  <= start_d;
            ureset_q <= ureset_d;
            idle_q   <= idle_d;
            unimpl_q <= unimpl_d;
            empty_q  <= empty_d;
        end
    end

    // caep1_d already reflects a caep1 kick this cycle, so its launch never stalls.
    assign disp.disp_stall        = !caep1_d && (!idle_q || kick);
    assign disp.disp_aeg_cnt      = 18'(NA);
    assign disp.disp_exception    = exc;
    assign disp.disp_rtn_data     = rtn_data;
    assign disp.disp_rtn_data_vld = rtn_vld;
    assign disp.disp_idle         = idle_q;
    assign unit_start             = start_q;
    assign unit_reset             = ureset_q;

endmodule

// File: tb/tb_dispatch_mc.sv
// Bench for dispatch_mc: directed AEG/CAEP vectors push expected read data,
// exceptions and start pulses into queues drained by negedge monitors.
module tb_dispatch_mc;

    localparam int NU   = 4;
    localparam int NA   = 8;
    localparam int FREQ = 150;
    localparam int PART = 'h5A17;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    num_ae  = 4'd2;
    logic [47:0]   ctl_que_base;
    logic [NU-1:0] unit_start;
    logic [NU-1:0] unit_reset;
    logic [NU-1:0] unit_busy = '0;
    logic          rd_d1     = 1'b0;

    logic [63:0]   rd_q[$];
    logic [15:0]   exc_q[$];
    logic [NU-1:0] start_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    dispatch_mc_if ifc ();

    dispatch_mc #(
        .FREQ    (FREQ),
        .PART    (PART),
        .NA      (NA),
        .NU      (NU),
        .RST_CYC (3),
        .IDL_CYC (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp       (ifc),
        .num_ae     (num_ae),
        .ctlQueBase (ctl_que_base),
        .unit_start (unit_start),
        .unit_reset (unit_reset),
        .unit_busy  (unit_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic noteUnexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got %h, expected no output", name, act);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one cycle of dispatch inputs; exp_stall < 0 skips the stall check.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [17:0] idx,
                                 input logic [63:0] wdata, input logic ivld,
                                 input logic [4:0] op, input int exp_stall);
        ifc.disp_aeg_rd      = rd;
        ifc.disp_aeg_wr      = wr;
        ifc.disp_aeg_idx     = idx;
        ifc.disp_aeg_wr_data = wdata;
        ifc.disp_inst_vld    = ivld;
        ifc.disp_inst        = op;
        #1;
        if (exp_stall >= 0) checkOutput("disp_stall", 64'(ifc.disp_stall), 64'(exp_stall));
        tick(1);
        ifc.disp_aeg_rd   = 1'b0;
        ifc.disp_aeg_wr   = 1'b0;
        ifc.disp_inst_vld = 1'b0;
    endtask

    task automatic aegRead(input logic [17:0] idx, input logic [63:0] exp);
        rd_q.push_back(exp);
        applyStimulus(1'b1, 1'b0, idx, 64'h0, 1'b0, 5'd0, -1);
    endtask

    task automatic aegWrite(input logic [17:0] idx, input logic [63:0] data);
        applyStimulus(1'b0, 1'b1, idx, data, 1'b0, 5'd0, -1);
    endtask

    task automatic caep(input logic [4:0] op, input int exp_stall);
        applyStimulus(1'b0, 1'b0, 18'd0, 64'h0, 1'b1, op, exp_stall);
    endtask

    always @(posedge clk) rd_d1 <= ifc.disp_aeg_rd;

    always @(negedge clk) begin
        if (rd_d1 || ifc.disp_rtn_data_vld)
            checkOutput("rtn_vld_latency", 64'(ifc.disp_rtn_data_vld), 64'(rd_d1));
        if (ifc.disp_rtn_data_vld === 1'b1) begin
            if (rd_q.size() == 0) noteUnexpected("rtn_data", ifc.disp_rtn_data);
            else checkOutput("rtn_data", ifc.disp_rtn_data, rd_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ifc.disp_exception !== 16'h0) begin
            if (exc_q.size() == 0) noteUnexpected("exception", 64'(ifc.disp_exception));
            else checkOutput("exception", 64'(ifc.disp_exception), 64'(exc_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (unit_start !== '0) begin
            if (start_q.size() == 0) noteUnexpected("unit_start", 64'(unit_start));
            else checkOutput("unit_start", 64'(unit_start), 64'(start_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifc.disp_inst_vld    = 1'b0;
        ifc.disp_inst        = 5'd0;
        ifc.disp_aeg_idx     = 18'd0;
        ifc.disp_aeg_rd      = 1'b0;
        ifc.disp_aeg_wr      = 1'b0;
        ifc.disp_aeg_wr_data = 64'h0;

        tick(3);
        checkOutput("rst_unit_reset", 64'(unit_reset), 64'hF);
        checkOutput("rst_unit_start", 64'(unit_start), 64'h0);
        checkOutput("rst_idle", 64'(ifc.disp_idle), 64'h1);
        checkOutput("rst_exception", 64'(ifc.disp_exception), 64'h0);
        checkOutput("rst_rtn_vld", 64'(ifc.disp_rtn_data_vld), 64'h0);
        checkOutput("aeg_cnt", 64'(ifc.disp_aeg_cnt), 64'(NA));
        reset_n = 1'b1;
        tick(1);

        $display("[TB] AEG constant and status reads");
        aegRead(18'd3, 64'h0000_0002_0096_0104);
        aegRead(18'd5, 64'hF);
        aegRead(18'd2, 64'h5A17);
        aegRead(18'd4, 64'h1);

        $display("[TB] caep0 launch with mask 0101");
        aegWrite(18'd5, 64'hFFFF_FFFF_FFFF_FFF5);
        aegRead(18'd5, 64'h5);
        start_q.push_back(4'b0101);
        caep(5'd0, 1);
        checkOutput("launch_idle", 64'(ifc.disp_idle), 64'h0);
        checkOutput("launch_reset", 64'(unit_reset), 64'hF);
        tick(3);
        checkOutput("start_timing", 64'(unit_start), 64'h5);
        checkOutput("start_reset", 64'(unit_reset), 64'hA);
        unit_busy = 4'b0011;
        tick(3);
        aegRead(18'd4, 64'h6);
        checkOutput("busy_reset_gated", 64'(unit_reset), 64'hA);
        aegWrite(18'd5, 64'hF);
        tick(5);
        checkOutput("mask_not_relatched", 64'(unit_reset), 64'hA);
        unit_busy = 4'b0010;
        tick(2);
        checkOutput("idle_hysteresis_hold", 64'(ifc.disp_idle), 64'h0);
        tick(1);
        checkOutput("idle_hysteresis_done", 64'(ifc.disp_idle), 64'h1);
        checkOutput("idle_reset_all", 64'(unit_reset), 64'hF);

        $display("[TB] caep1 launch is non-blocking");
        unit_busy = '0;
        start_q.push_back(4'hF);
        caep(5'd1, 0);
        for (int c = 1; c <= 9; c++) begin
            if (c == 4) checkOutput("caep1_start", 64'(unit_start), 64'hF);
            if (c == 7) caep(5'd0, 0);
            else begin
                #1;
                checkOutput("caep1_stall", 64'(ifc.disp_stall), 64'h0);
                tick(1);
            end
        end
        checkOutput("caep1_back_idle", 64'(ifc.disp_idle), 64'h1);

        $display("[TB] exception pulses and sticky AEG1");
        exc_q.push_back(16'h0004);
        aegWrite(18'd3, 64'h1234);
        exc_q.push_back(16'h0002);
        aegRead(18'(NA), 64'hdeadbeefdeadbeef);
        exc_q.push_back(16'h0001);
        caep(5'd5, -1);
        aegWrite(18'd5, 64'h0);
        exc_q.push_back(16'h0008);
        caep(5'd0, 0);
        tick(1);
        checkOutput("empty_mask_no_launch", 64'(ifc.disp_idle), 64'h1);
        aegRead(18'd1, 64'hF);
        aegRead(18'd3, 64'h0000_0002_0096_0104);

        $display("[TB] same-cycle read/write and sticky write race");
        aegWrite(18'd0, 64'h1111_2222_3333_4444);
        rd_q.push_back(64'h1111_2222_3333_4444);
        applyStimulus(1'b1, 1'b1, 18'd0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 5'd0, -1);
        aegRead(18'd0, 64'hAAAA_BBBB_CCCC_DDDD);
        checkOutput("ctlQueBase", 64'(ctl_que_base), 64'h0000_BBBB_CCCC_DDDD);
        exc_q.push_back(16'h0001);
        caep(5'd7, -1);
        aegWrite(18'd1, 64'h0);
        aegRead(18'd1, 64'h1);

        $display("[TB] reset mid-BUSY");
        aegWrite(18'd5, 64'h3);
        start_q.push_back(4'b0011);
        caep(5'd0, 1);
        tick(3);
        checkOutput("rst_test_start", 64'(unit_start), 64'h3);
        unit_busy = 4'b0001;
        tick(4);
        checkOutput("rst_test_busy_reset", 64'(unit_reset), 64'hC);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_unit_reset", 64'(unit_reset), 64'hF);
        checkOutput("abort_unit_start", 64'(unit_start), 64'h0);
        checkOutput("abort_idle", 64'(ifc.disp_idle), 64'h1);
        tick(2);
        reset_n   = 1'b1;
        unit_busy = '0;
        tick(8);
        checkOutput("post_reset_idle", 64'(ifc.disp_idle), 64'h1);
        aegRead(18'd5, 64'hF);
        aegRead(18'd0, 64'h0);

        tick(3);
        checkOutput("rd_queue_drained", 64'(rd_q.size()), 64'h0);
        checkOutput("exc_queue_drained", 64'(exc_q.size()), 64'h0);
        checkOutput("start_queue_drained", 64'(start_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
